vga_sync_module: RTL and testbench
==================================

Name: vga_sync_module

Overview:
- Timing controller that sequences the VGA pixel colour path. It owns the horizontal and vertical counters for 800x600@60Hz (40 MHz pixel clock).
- Drives Ready_Sig, Column_Addr_Sig and Row_Addr_Sig into vga_control_module, and HSYNC/VSYNC to the pins.
- Contains a frame-based test-pattern scheduler whose select drives the colour module's pattern mux.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (clocks)
- H_SYNC, 128, HSYNC pulse width
- H_BACK, 88, horizontal back porch (H_TOTAL = 1056)
- V_VISIBLE, 600, active lines
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, VSYNC width
- V_BACK, 23, vertical back porch (V_TOTAL = 628)
- SYNC_POL, 1, active level of HSYNC/VSYNC
- PATTERN_NUM, 4, number of patterns (1..4)
- FRAMES_PER_PATTERN, 120, frames per pattern in auto mode (>=1)

Ports:
- CLK  in  1  pixel clock, 40 MHz
- RST  in  1  asynchronous, active-high reset
- Auto_En  in  1  1 = pattern advances automatically every FRAMES_PER_PATTERN frames
- Next_Pattern  in  1  single-cycle request to advance the pattern at the next frame boundary
- Ready_Sig  out  1  current Column/Row address is in the visible area
- Column_Addr_Sig  out  11  pixel column 0..799 while Ready_Sig=1, else 0
- Row_Addr_Sig  out  10  pixel row 0..599 while Ready_Sig=1, else 0
- HSYNC_Sig  out  1  horizontal sync
- VSYNC_Sig  out  1  vertical sync
- Frame_Start_Sig  out  1  one-cycle pulse, aligned with Ready_Sig for pixel (0,0)
- Pattern_Sel  out  2  active pattern index, 0..PATTERN_NUM-1

Behaviour:
- Reset is asynchronous on RST=1 and is honoured mid-frame. On reset:
  - h_cnt = 0, v_cnt = 0.
  - Ready_Sig, Column_Addr_Sig, Row_Addr_Sig and Frame_Start_Sig = 0.
  - HSYNC_Sig and VSYNC_Sig = ~SYNC_POL.
  - Pattern_Sel = 0, frame counter = 0, pending request = 0.
- Counters:
  - h_cnt advances 0..H_TOTAL-1 every clock and wraps to 0.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1, then wraps.
  - Regions (horizontal): visible 0..799; front porch 800..839; sync 840..967; back porch 968..1055.
  - Regions (vertical): visible 0..599; front porch 600; sync 601..604; back porch 605..627.
- Stage 1 (one register after the counters; these three are mutually aligned):
  - Ready_Sig = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - Column_Addr_Sig = h_cnt if visible, else 0.
  - Row_Addr_Sig = v_cnt if visible, else 0.
- Stage 2 (one further register, so sync matches the colour module's one-cycle colour register):
  - HSYNC_Sig = SYNC_POL while h_cnt is in the sync region, else ~SYNC_POL.
  - VSYNC_Sig = SYNC_POL while v_cnt is in 601..604, for entire lines, else ~SYNC_POL.
- Frame_Start_Sig is 1 for exactly the stage-1 cycle in which the address is (0,0) with Ready_Sig=1.
- First visible pixel appears on the first rising edge after RST deasserts.
- Pattern scheduler, updated only on the frame boundary (h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1):
  - A Next_Pattern pulse sets a pending flag. Multiple pulses within one frame collapse into a single advance.
  - Boundary with pending=1: advance Pattern_Sel, clear pending, clear frame counter.
  - Else, Auto_En=1: increment the frame counter; on reaching FRAMES_PER_PATTERN-1, advance Pattern_Sel and clear the counter.
  - Else, Auto_En=0: hold the frame counter.
  - Advance wraps from PATTERN_NUM-1 to 0.
  - A Next_Pattern pulse arriving on the boundary cycle itself is registered as pending for the following boundary.
- Pattern_Sel changes only between frames, never mid-frame.
- Width rules: all comparisons unsigned; counters sized 11 bits (h) and 10 bits (v); the frame counter is sized for FRAMES_PER_PATTERN.

Decomposition:
- Shared package vga_timing_pkg holds the 800x600@60 timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL, SYNC_POL) and the pattern-index encoding. vga_control_module reuses the same visible-area limits from it.
- One sub-module is natural: vga_pattern_scheduler_module (pending flag, frame counter, Pattern_Sel), fed by a frame-boundary strobe from the counter logic.

Test Plan:
- Reset, then release, then run 1056 clocks:
  - Ready_Sig is high for exactly 800 consecutive cycles, with Column_Addr_Sig 0..799.
  - HSYNC_Sig is low (SYNC_POL=1 inactive) except a 128-cycle high pulse starting 840+2 cycles after h_cnt=0.
- Run one full frame (663168 clocks):
  - exactly 600 lines contain Ready pixels; Row_Addr_Sig goes 0..599.
  - VSYNC_Sig is high for 4x1056 clocks.
  - Frame_Start_Sig pulses once per frame.
- Auto_En=1 with FRAMES_PER_PATTERN overridden to 2:
  - Pattern_Sel steps 0,1,2,3,0 every 2 frames.
  - Each change occurs only on the frame-boundary cycle.
- Auto_En=0, with 3 Next_Pattern pulses inside frame 5:
  - Pattern_Sel advances by exactly 1 at the frame-5/6 boundary, then holds.
- Assert RST mid-frame at h=500, v=300:
  - all outputs immediately take their reset values.
  - After release, Column/Row restart at (0,0) with Frame_Start_Sig=1 on the first edge.
- Next_Pattern asserted on the boundary cycle itself:
  - no advance at that boundary; Pattern_Sel advances at the next boundary.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 timing defaults and test-pattern index encoding for the
// VGA sync and colour modules.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE = 800;
    localparam int unsigned DEF_H_FRONT   = 40;
    localparam int unsigned DEF_H_SYNC    = 128;
    localparam int unsigned DEF_H_BACK    = 88;
    localparam int unsigned DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int unsigned DEF_V_VISIBLE = 600;
    localparam int unsigned DEF_V_FRONT   = 1;
    localparam int unsigned DEF_V_SYNC    = 4;
    localparam int unsigned DEF_V_BACK    = 23;
    localparam int unsigned DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam logic DEF_SYNC_POL = 1'b1;

    localparam int unsigned DEF_PATTERN_NUM        = 4;
    localparam int unsigned DEF_FRAMES_PER_PATTERN = 120;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRID     = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_e;

    // Advance with wrap from num-1 back to the first pattern.
    function automatic logic [1:0] next_pattern(input logic [1:0] cur, input int unsigned num);
        return (32'(cur) >= num - 1) ? 2'd0 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/vga_pattern_scheduler_module.sv
// Frame-based test-pattern scheduler: manual requests collapse into one
// advance per frame, otherwise auto-advance every FRAMES_PER_PATTERN frames.
module vga_pattern_scheduler_module
    import vga_timing_pkg::*;
#(
    parameter int unsigned PATTERN_NUM        = DEF_PATTERN_NUM,
    parameter int unsigned FRAMES_PER_PATTERN = DEF_FRAMES_PER_PATTERN
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Auto_En,
    input  logic       Next_Pattern,
    input  logic       Frame_End,
    output logic [1:0] Pattern_Sel
);

    localparam int unsigned FCW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_PATTERN - 1);

    logic [FCW-1:0] frame_cnt;
    logic           pending;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Pattern_Sel <= '0;
            frame_cnt   <= '0;
            pending     <= 1'b0;
        end else if (Frame_End) begin
            // A request on the boundary cycle itself is kept for the next frame.
            pending <= Next_Pattern;
            if (pending) begin
                Pattern_Sel <= next_pattern(Pattern_Sel, PATTERN_NUM);
                frame_cnt   <= '0;
            end else if (Auto_En) begin
                if (frame_cnt == FRAME_LAST) begin
                    Pattern_Sel <= next_pattern(Pattern_Sel, PATTERN_NUM);
                    frame_cnt   <= '0;
                end else begin
                    frame_cnt <= frame_cnt + FCW'(1);
                end
            end
        end else if (Next_Pattern) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_module.sv
// VGA timing controller: h/v counters, registered pixel address and ready,
// sync pulses delayed one extra stage to line up with the colour register.
module vga_sync_module
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE          = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT            = DEF_H_FRONT,
    parameter int unsigned H_SYNC             = DEF_H_SYNC,
    parameter int unsigned H_BACK             = DEF_H_BACK,
    parameter int unsigned V_VISIBLE          = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT            = DEF_V_FRONT,
    parameter int unsigned V_SYNC             = DEF_V_SYNC,
    parameter int unsigned V_BACK             = DEF_V_BACK,
    parameter logic        SYNC_POL           = DEF_SYNC_POL,
    parameter int unsigned PATTERN_NUM        = DEF_PATTERN_NUM,
    parameter int unsigned FRAMES_PER_PATTERN = DEF_FRAMES_PER_PATTERN
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Auto_En,
    input  logic        Next_Pattern,
    output logic        Ready_Sig,
    output logic [10:0] Column_Addr_Sig,
    output logic [9:0]  Row_Addr_Sig,
    output logic        HSYNC_Sig,
    output logic        VSYNC_Sig,
    output logic        Frame_Start_Sig,
    output logic [1:0]  Pattern_Sel
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        h_end;
    logic        frame_end;
    logic        visible;
    logic        h_sync_on;
    logic        v_sync_on;
    logic        hsync_s1;
    logic        vsync_s1;

    always_comb begin
        h_end     = (h_cnt == H_LAST);
        frame_end = h_end && (v_cnt == V_LAST);
        visible   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        h_sync_on = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        v_sync_on = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Ready_Sig       <= 1'b0;
            Column_Addr_Sig <= '0;
            Row_Addr_Sig    <= '0;
            Frame_Start_Sig <= 1'b0;
            hsync_s1        <= ~SYNC_POL;
            vsync_s1        <= ~SYNC_POL;
            HSYNC_Sig       <= ~SYNC_POL;
            VSYNC_Sig       <= ~SYNC_POL;
        end else begin
            Ready_Sig       <= visible;
            Column_Addr_Sig <= visible ? h_cnt : '0;
            Row_Addr_Sig    <= visible ? v_cnt : '0;
            Frame_Start_Sig <= (h_cnt == '0) && (v_cnt == '0);
            hsync_s1        <= h_sync_on ? SYNC_POL : ~SYNC_POL;
            vsync_s1        <= v_sync_on ? SYNC_POL : ~SYNC_POL;
            HSYNC_Sig       <= hsync_s1;
            VSYNC_Sig       <= vsync_s1;
        end
    end

    vga_pattern_scheduler_module #(
        .PATTERN_NUM        (PATTERN_NUM),
        .FRAMES_PER_PATTERN (FRAMES_PER_PATTERN)
    ) u_sched (
        .CLK          (CLK),
        .RST          (RST),
        .Auto_En      (Auto_En),
        .Next_Pattern (Next_Pattern),
        .Frame_End    (frame_end),
        .Pattern_Sel  (Pattern_Sel)
    );

endmodule

// File: tb/tb_vga_sync_module.sv
// Scoreboard bench: a scaled-timing instance (32x16 total, 2 frames/pattern)
// for frame/pattern/reset behaviour, and a default-timing instance for lines.
module tb_vga_sync_module;

    typedef struct {
        int unsigned k;
        int unsigned col;
        int unsigned row;
        int unsigned fs;
        int unsigned pat;
    } px_t;

    localparam int unsigned S_FRAME = 512;
    localparam int unsigned PAT_A [11] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
    localparam int unsigned PAT_B [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2};

    logic CLK;
    logic rst_s, rst_f;
    logic ae_s, np_s, ae_f, np_f;

    logic        s_ready, s_hs, s_vs, s_fs;
    logic [10:0] s_col;
    logic [9:0]  s_row;
    logic [1:0]  s_pat;
    logic        f_ready, f_hs, f_vs, f_fs;
    logic [10:0] f_col;
    logic [9:0]  f_row;
    logic [1:0]  f_pat;

    px_t q_s[$];
    px_t q_f[$];
    int unsigned k_s, k_f;
    int total = 0;
    int bad = 0;
    int end_req_s = 0;
    int end_req_f = 0;

    vga_sync_module #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b1), .PATTERN_NUM(4), .FRAMES_PER_PATTERN(2)
    ) dut_s (
        .CLK(CLK), .RST(rst_s), .Auto_En(ae_s), .Next_Pattern(np_s),
        .Ready_Sig(s_ready), .Column_Addr_Sig(s_col), .Row_Addr_Sig(s_row),
        .HSYNC_Sig(s_hs), .VSYNC_Sig(s_vs), .Frame_Start_Sig(s_fs), .Pattern_Sel(s_pat)
    );

    vga_sync_module dut_f (
        .CLK(CLK), .RST(rst_f), .Auto_En(ae_f), .Next_Pattern(np_f),
        .Ready_Sig(f_ready), .Column_Addr_Sig(f_col), .Row_Addr_Sig(f_row),
        .HSYNC_Sig(f_hs), .VSYNC_Sig(f_vs), .Frame_Start_Sig(f_fs), .Pattern_Sel(f_pat)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK or posedge rst_s)
        if (rst_s) k_s <= 0; else k_s <= k_s + 1;
    always @(posedge CLK or posedge rst_f)
        if (rst_f) k_f <= 0; else k_f <= k_f + 1;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_edges(input int unsigned n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Expected pixels of one scaled frame with counter position <= last_c.
    task automatic push_s(input int unsigned f, input int unsigned pat, input int unsigned last_c);
        for (int unsigned r = 0; r < 10; r++)
            for (int unsigned c = 0; c < 16; c++)
                if (r * 32 + c <= last_c)
                    q_s.push_back('{k: f * S_FRAME + r * 32 + c + 1, col: c, row: r,
                                    fs: ((r == 0) && (c == 0)) ? 1 : 0, pat: pat});
    endtask

    function automatic bit in_rng(input int unsigned x, input int unsigned lo, input int unsigned hi);
        return (x >= lo) && (x <= hi);
    endfunction

    // Monitor: pops the scoreboard on every Ready pixel and checks idle/sync/reset values.
    initial begin
        px_t e;
        int unsigned c;
        int end_seen_s;
        int end_seen_f;
        logic [1:0] prev_s;
        end_seen_s = 0;
        end_seen_f = 0;
        prev_s = 2'd0;
        forever begin
            @(negedge CLK);
            if (rst_s) begin
                chk("s_rst_ready", s_ready, 0);
                chk("s_rst_col", s_col, 0);
                chk("s_rst_row", s_row, 0);
                chk("s_rst_fs", s_fs, 0);
                chk("s_rst_hsync", s_hs, 0);
                chk("s_rst_vsync", s_vs, 0);
                chk("s_rst_pat", s_pat, 0);
            end else begin
                if (s_ready) begin
                    if (q_s.size() == 0) chk("s_px_extra", q_s.size(), 1);
                    else begin
                        e = q_s.pop_front();
                        chk("s_px_cycle", k_s, e.k);
                        chk("s_px_col", s_col, e.col);
                        chk("s_px_row", s_row, e.row);
                        chk("s_px_fs", s_fs, e.fs);
                        chk("s_px_pat", s_pat, e.pat);
                    end
                end else begin
                    chk("s_idle_col", s_col, 0);
                    chk("s_idle_row", s_row, 0);
                    chk("s_idle_fs", s_fs, 0);
                end
                c = (k_s >= 2) ? (k_s - 2) % S_FRAME : 0;
                chk("s_hsync", s_hs, ((k_s >= 2) && in_rng(c % 32, 20, 25)) ? 1 : 0);
                chk("s_vsync", s_vs, ((k_s >= 2) && in_rng(c / 32, 11, 12)) ? 1 : 0);
                chk("s_pat_midframe",
                    ((s_pat != prev_s) && !((k_s % S_FRAME == 0) && (k_s != 0))) ? 1 : 0, 0);
            end
            prev_s = s_pat;
            if (end_req_s != end_seen_s) begin
                chk("s_queue_drained", q_s.size(), 0);
                end_seen_s = end_req_s;
            end

            if (rst_f) begin
                chk("f_rst_ready", f_ready, 0);
                chk("f_rst_hsync", f_hs, 0);
                chk("f_rst_vsync", f_vs, 0);
                chk("f_rst_col", f_col, 0);
                chk("f_rst_pat", f_pat, 0);
            end else begin
                if (f_ready) begin
                    if (q_f.size() == 0) chk("f_px_extra", q_f.size(), 1);
                    else begin
                        e = q_f.pop_front();
                        chk("f_px_cycle", k_f, e.k);
                        chk("f_px_col", f_col, e.col);
                        chk("f_px_row", f_row, e.row);
                        chk("f_px_fs", f_fs, e.fs);
                        chk("f_px_pat", f_pat, e.pat);
                    end
                end else begin
                    chk("f_idle_col", f_col, 0);
                    chk("f_idle_row", f_row, 0);
                    chk("f_idle_fs", f_fs, 0);
                end
                c = (k_f >= 2) ? (k_f - 2) % (1056 * 628) : 0;
                chk("f_hsync", f_hs, ((k_f >= 2) && in_rng(c % 1056, 840, 967)) ? 1 : 0);
                chk("f_vsync", f_vs, ((k_f >= 2) && in_rng(c / 1056, 601, 604)) ? 1 : 0);
            end
            if (end_req_f != end_seen_f) begin
                chk("f_queue_drained", q_f.size(), 0);
                end_seen_f = end_req_f;
            end
        end
    end

    initial begin
        rst_s = 1'b1; rst_f = 1'b1;
        ae_s = 1'b1; np_s = 1'b0;
        ae_f = 1'b0; np_f = 1'b0;

        // Auto mode: frames 0..9 complete, frame 10 cut by reset after pixel (8,5).
        for (int unsigned f = 0; f < 10; f++) push_s(f, PAT_A[f], S_FRAME - 1);
        push_s(10, PAT_A[10], 168);
        for (int unsigned r = 0; r < 3; r++)
            for (int unsigned c = 0; c < 800; c++)
                q_f.push_back('{k: r * 1056 + c + 1, col: c, row: r,
                                fs: ((r == 0) && (c == 0)) ? 1 : 0, pat: 0});

        run_edges(3);
        rst_s = 1'b0;
        rst_f = 1'b0;

        fork
            begin
                run_edges(3168);
                rst_f = 1'b1;
                end_req_f = 1;
            end
            begin
                run_edges(10 * S_FRAME + 170);
                rst_s = 1'b1;
                end_req_s = 1;
                run_edges(3);

                ae_s = 1'b0;
                for (int unsigned f = 0; f < 11; f++) push_s(f, PAT_B[f], S_FRAME - 1);
                rst_s = 1'b0;
                // Three requests inside frame 5.
                run_edges(2600); np_s = 1'b1; run_edges(1); np_s = 1'b0;
                run_edges(99);   np_s = 1'b1; run_edges(1); np_s = 1'b0;
                run_edges(199);  np_s = 1'b1; run_edges(1); np_s = 1'b0;
                // Request held on the end-of-frame-7 boundary cycle.
                run_edges(1194); np_s = 1'b1; run_edges(1); np_s = 1'b0;
                run_edges(1536);
                rst_s = 1'b1;
                end_req_s = 2;
            end
        join

        run_edges(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
